// File: rtl/ysyx_24100006_wbu_pipe_if.sv
// Write-back stage bus: MEM_WB-side valid/ready entry plus the registered register-file write ports.
// `WBU_DIFFTEST_EN adds in_npc/mtvec inputs and the npc_dbg output.
interface ysyx_24100006_wbu_pipe_if #(
  parameter int XLEN   = 32,
  parameter int GPR_AW = 4,
  parameter int CSR_AW = 12,
  parameter int IRQ_NW = 8,
  parameter int CNT_W  = 64
) ();
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_alu;
  logic [XLEN-1:0]   in_mem;
  logic [XLEN-1:0]   in_csr_rdata;
  logic [XLEN-1:0]   in_rs1;
  logic              in_gpr_we;
  logic [GPR_AW-1:0] in_gpr_addr;
  logic [2:0]        in_gpr_sel;
  logic              in_csr_we;
  logic [CSR_AW-1:0] in_csr_addr;
  logic [1:0]        in_csr_sel;
  logic              in_irq;
  logic [IRQ_NW-1:0] in_irq_no;
  logic              in_break;

  logic              out_valid;
  logic              out_ready;
  logic              gpr_we;
  logic [GPR_AW-1:0] gpr_waddr;
  logic [XLEN-1:0]   gpr_wdata;
  logic              csr_we;
  logic [CSR_AW-1:0] csr_waddr;
  logic [XLEN-1:0]   csr_wdata;
  logic              irq_o;
  logic [IRQ_NW-1:0] irq_no_o;
  logic              halted;
  logic [CNT_W-1:0]  retire_cnt;
`ifdef WBU_DIFFTEST_EN
  logic [XLEN-1:0]   in_npc;
  logic [XLEN-1:0]   mtvec;
  logic [XLEN-1:0]   npc_dbg;
`endif

  // slave = the write-back stage, master = whoever drives MEM_WB and consumes the write ports
  modport slave (
    input  in_valid, in_pc, in_imm, in_alu, in_mem, in_csr_rdata, in_rs1,
           in_gpr_we, in_gpr_addr, in_gpr_sel, in_csr_we, in_csr_addr, in_csr_sel,
           in_irq, in_irq_no, in_break, out_ready,
`ifdef WBU_DIFFTEST_EN
    input  in_npc, mtvec,
    output npc_dbg,
`endif
    output in_ready, out_valid, gpr_we, gpr_waddr, gpr_wdata, csr_we, csr_waddr,
           csr_wdata, irq_o, irq_no_o, halted, retire_cnt
  );

  modport master (
    output in_valid, in_pc, in_imm, in_alu, in_mem, in_csr_rdata, in_rs1,
           in_gpr_we, in_gpr_addr, in_gpr_sel, in_csr_we, in_csr_addr, in_csr_sel,
           in_irq, in_irq_no, in_break, out_ready,
`ifdef WBU_DIFFTEST_EN
    output in_npc, mtvec,
    input  npc_dbg,
`endif
    input  in_ready, out_valid, gpr_we, gpr_waddr, gpr_wdata, csr_we, csr_waddr,
           csr_wdata, irq_o, irq_no_o, halted, retire_cnt
  );
endinterface

// File: rtl/ysyx_24100006_wbu_pipe.sv
// Registered write-back stage: GPR/CSR write-data select, x0 suppression, retire counter, sticky ebreak halt.
// Optional `WBU_DIFFTEST_EN tracks the committed next-PC on npc_dbg.
module ysyx_24100006_wbu_pipe #(
  parameter int XLEN   = 32,
  parameter int GPR_AW = 4,
  parameter int CSR_AW = 12,
  parameter int IRQ_NW = 8,
  parameter int CNT_W  = 64
) (
  input logic clk,
  input logic reset,
  ysyx_24100006_wbu_pipe_if.slave bus
);

  logic              r_out_valid;
  logic              r_gpr_we;
  logic [GPR_AW-1:0] r_gpr_waddr;
  logic [XLEN-1:0]   r_gpr_wdata;
  logic              r_csr_we;
  logic [CSR_AW-1:0] r_csr_waddr;
  logic [XLEN-1:0]   r_csr_wdata;
  logic              r_irq;
  logic [IRQ_NW-1:0] r_irq_no;
  logic              r_break;
  logic              r_halted;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_out_hs;
  logic [XLEN-1:0]   w_gpr_wdata;
  logic              w_gpr_sel_ok;
  logic [XLEN-1:0]   w_csr_wdata;

  assign w_in_ready = !r_halted && (!r_out_valid || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && bus.out_ready;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_gpr_wdata  = '0;
    w_gpr_sel_ok = 1'b1;
    unique case (bus.in_gpr_sel)
      3'd0:    w_gpr_wdata = bus.in_imm;
      3'd1:    w_gpr_wdata = bus.in_alu;
      3'd2:    w_gpr_wdata = bus.in_pc + XLEN'(4);
      3'd3:    w_gpr_wdata = bus.in_mem;
      3'd4:    w_gpr_wdata = bus.in_csr_rdata;
      default: w_gpr_sel_ok = 1'b0;
    endcase

    w_csr_wdata = '0;
    unique case (bus.in_csr_sel)
      2'd0: w_csr_wdata = bus.in_pc;
      2'd1: w_csr_wdata = bus.in_rs1;
      2'd2: w_csr_wdata = bus.in_csr_rdata | bus.in_rs1;
      2'd3: w_csr_wdata = bus.in_csr_rdata & ~bus.in_rs1;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_out_valid  <= 1'b0;
      r_gpr_we     <= 1'b0;
      r_gpr_waddr  <= '0;
      r_gpr_wdata  <= '0;
      r_csr_we     <= 1'b0;
      r_csr_waddr  <= '0;
      r_csr_wdata  <= '0;
      r_irq        <= 1'b0;
      r_irq_no     <= '0;
      r_break      <= 1'b0;
      r_halted     <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      if (w_out_hs) begin
        r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        if (r_break) r_halted <= 1'b1;
      end
      // A simultaneous accept overwrites the committing entry, so the stage never bubbles.
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_gpr_we    <= bus.in_gpr_we && (bus.in_gpr_addr != '0) && w_gpr_sel_ok;
        r_gpr_waddr <= bus.in_gpr_addr;
        r_gpr_wdata <= w_gpr_wdata;
        r_csr_we    <= bus.in_csr_we;
        r_csr_waddr <= bus.in_csr_addr;
        r_csr_wdata <= w_csr_wdata;
        r_irq       <= bus.in_irq;
        r_irq_no    <= bus.in_irq_no;
        r_break     <= bus.in_break;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
        r_gpr_we    <= 1'b0;
        r_csr_we    <= 1'b0;
        r_irq       <= 1'b0;
        r_break     <= 1'b0;
      end
    end
  end

`ifdef WBU_DIFFTEST_EN
  logic [XLEN-1:0] r_npc;
  logic [XLEN-1:0] r_npc_dbg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_npc     <= '0;
      r_npc_dbg <= '0;
    end else begin
      if (w_out_hs) r_npc_dbg <= r_irq ? bus.mtvec : r_npc;
      if (w_accept) r_npc     <= bus.in_npc;
    end
  end

  assign bus.npc_dbg = r_npc_dbg;
`endif

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.gpr_we     = r_gpr_we;
  assign bus.gpr_waddr  = r_gpr_waddr;
  assign bus.gpr_wdata  = r_gpr_wdata;
  assign bus.csr_we     = r_csr_we;
  assign bus.csr_waddr  = r_csr_waddr;
  assign bus.csr_wdata  = r_csr_wdata;
  assign bus.irq_o      = r_irq;
  assign bus.irq_no_o   = r_irq_no;
  assign bus.halted     = r_halted;
  assign bus.retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_ysyx_24100006_wbu_pipe.sv
// Scoreboard bench for ysyx_24100006_wbu_pipe: directed entries push expected write ports,
// a negedge monitor pops and compares on every output handshake.
module tb_ysyx_24100006_wbu_pipe;

  typedef struct packed {
    logic [31:0] pc, imm, alu, mem, crd, rs1;
    logic        gwe;
    logic [3:0]  ga;
    logic [2:0]  gsel;
    logic        cwe;
    logic [11:0] ca;
    logic [1:0]  csel;
    logic        irq;
    logic [7:0]  irqno;
    logic        brk;
  } stim_t;

  typedef struct packed {
    logic        gwe;
    logic [3:0]  ga;
    logic [31:0] gd;
    logic        cwe;
    logic [11:0] ca;
    logic [31:0] cd;
    logic        irq;
    logic [7:0]  irqno;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ysyx_24100006_wbu_pipe_if bus ();

  ysyx_24100006_wbu_pipe dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_sent   = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: commit point is the posedge following a negedge that sees out_valid && out_ready.
  exp_t        mon_act;
  exp_t        mon_exp;
  logic [91:0] snap;
  logic        stall_prev = 1'b0;

  always @(negedge clk) begin
    mon_act = {bus.gpr_we, bus.gpr_waddr, bus.gpr_wdata, bus.csr_we, bus.csr_waddr,
               bus.csr_wdata, bus.irq_o, bus.irq_no_o};
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q.size() == 0) check("unexpected_entry", {36'd0, mon_act}, 128'd0);
      else begin
        mon_exp = q.pop_front();
        check("entry", {37'd0, mon_act}, {37'd0, mon_exp});
      end
    end
    if (reset === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
      if (stall_prev) check("stall_stable", {36'd0, bus.out_valid, mon_act}, {36'd0, snap});
      snap       = {bus.out_valid, mon_act};
      stall_prev = 1'b1;
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic drive(input stim_t s);
    bus.in_pc        = s.pc;
    bus.in_imm       = s.imm;
    bus.in_alu       = s.alu;
    bus.in_mem       = s.mem;
    bus.in_csr_rdata = s.crd;
    bus.in_rs1       = s.rs1;
    bus.in_gpr_we    = s.gwe;
    bus.in_gpr_addr  = s.ga;
    bus.in_gpr_sel   = s.gsel;
    bus.in_csr_we    = s.cwe;
    bus.in_csr_addr  = s.ca;
    bus.in_csr_sel   = s.csel;
    bus.in_irq       = s.irq;
    bus.in_irq_no    = s.irqno;
    bus.in_break     = s.brk;
  endtask

  // Called just after a posedge; returns just after the posedge that accepted the entry.
  task automatic send(input stim_t s, input exp_t e);
    bit acc = 1'b0;
    int cyc = 0;
    drive(s);
    bus.in_valid = 1'b1;
    while (!acc && cyc < 50) begin
      @(negedge clk);
      acc = (bus.in_ready === 1'b1);
      @(posedge clk);
      #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    if (!acc) check("send_timeout", 128'd0, 128'd1);
    else begin
      q.push_back(e);
      n_sent++;
      check("latency_out_valid", {127'd0, bus.out_valid}, 128'd1);
    end
  endtask

  function automatic stim_t zs();
    stim_t s = '0;
    return s;
  endfunction

  function automatic exp_t ze();
    exp_t e = '0;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    exp_t  e;
`ifdef WBU_DIFFTEST_EN
    bus.in_npc = '0;
    bus.mtvec  = '0;
`endif
    drive(zs());
    reset         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
      check("rst_retire_cnt", {64'd0, bus.retire_cnt}, 128'd0);
    end
    check("rst_halted", {127'd0, bus.halted}, 128'd0);
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
    @(posedge clk);
    #1;

    // Back-to-back ALU writes rd=1..4
    for (int i = 1; i <= 4; i++) begin
      s = zs(); s.gwe = 1; s.ga = 4'(i); s.gsel = 3'd1; s.alu = 32'h10 + 32'(i - 1);
      e = ze(); e.gwe = 1; e.ga = 4'(i); e.gd = 32'h10 + 32'(i - 1);
      send(s, e);
    end
    repeat (3) @(posedge clk);
    #1;
    check("retire_after_stream", {64'd0, bus.retire_cnt}, 128'd4);
    check("idle_out_valid", {127'd0, bus.out_valid}, 128'd0);
    check("idle_gpr_we", {127'd0, bus.gpr_we}, 128'd0);

    // x0 write of pc+4 with wrap: strobe suppressed, data 0
    s = zs(); s.gwe = 1; s.ga = 4'd0; s.gsel = 3'd2; s.pc = 32'hFFFF_FFFC;
    e = ze(); e.gwe = 0; e.ga = 4'd0; e.gd = 32'h0000_0000; e.cd = 32'hFFFF_FFFC;
    send(s, e);
    // imm select
    s = zs(); s.gwe = 1; s.ga = 4'd7; s.gsel = 3'd0; s.imm = 32'hFFFF_F800;
    e = ze(); e.gwe = 1; e.ga = 4'd7; e.gd = 32'hFFFF_F800;
    send(s, e);
    // mem select
    s = zs(); s.gwe = 1; s.ga = 4'd15; s.gsel = 3'd3; s.mem = 32'hDEAD_BEEF;
    e = ze(); e.gwe = 1; e.ga = 4'd15; e.gd = 32'hDEAD_BEEF;
    send(s, e);
    // csr_rdata to GPR, CSR set: 0x0F | 0xF0 = 0xFF
    s = zs(); s.gwe = 1; s.ga = 4'd2; s.gsel = 3'd4; s.crd = 32'h0F; s.rs1 = 32'hF0;
    s.cwe = 1; s.ca = 12'h300; s.csel = 2'd2;
    e = ze(); e.gwe = 1; e.ga = 4'd2; e.gd = 32'h0F; e.cwe = 1; e.ca = 12'h300; e.cd = 32'hFF;
    send(s, e);
    // CSR clear: 0xFF & ~0x0F = 0xF0, GPR write not requested
    s = zs(); s.gwe = 0; s.ga = 4'd6; s.gsel = 3'd1; s.alu = 32'h99; s.crd = 32'hFF; s.rs1 = 32'h0F;
    s.cwe = 1; s.ca = 12'h341; s.csel = 2'd3;
    e = ze(); e.gwe = 0; e.ga = 4'd6; e.gd = 32'h99; e.cwe = 1; e.ca = 12'h341; e.cd = 32'hF0;
    send(s, e);
    // Trap: mepc <- pc, link pc+4, irq passed through
    s = zs(); s.gwe = 1; s.ga = 4'd1; s.gsel = 3'd2; s.pc = 32'h8000_0000;
    s.cwe = 1; s.ca = 12'h341; s.csel = 2'd0; s.irq = 1; s.irqno = 8'h0B;
    e = ze(); e.gwe = 1; e.ga = 4'd1; e.gd = 32'h8000_0004; e.cwe = 1; e.ca = 12'h341;
    e.cd = 32'h8000_0000; e.irq = 1; e.irqno = 8'h0B;
    send(s, e);
    // Reserved select: no write, data 0
    s = zs(); s.gwe = 1; s.ga = 4'd3; s.gsel = 3'd5; s.alu = 32'h77; s.rs1 = 32'h5; s.csel = 2'd1;
    e = ze(); e.gwe = 0; e.ga = 4'd3; e.gd = 32'h0; e.cd = 32'h5;
    send(s, e);

    // Backpressure: out_ready low for three cycles in the middle of a stream
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          s = zs(); s.gwe = 1; s.ga = 4'(8 + i); s.gsel = 3'd1; s.alu = 32'h20 + 32'(i);
          e = ze(); e.gwe = 1; e.ga = 4'(8 + i); e.gd = 32'h20 + 32'(i);
          send(s, e);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("bp_in_ready", {127'd0, bus.in_ready}, 128'd0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk);
    #1;
    check("retire_total", {64'd0, bus.retire_cnt}, 128'(n_sent));

    // ebreak retiring together with an interrupt
    s = zs(); s.gwe = 1; s.ga = 4'd5; s.gsel = 3'd1; s.alu = 32'h55; s.brk = 1; s.irq = 1; s.irqno = 8'h03;
    e = ze(); e.gwe = 1; e.ga = 4'd5; e.gd = 32'h55; e.irq = 1; e.irqno = 8'h03;
    send(s, e);
    @(posedge clk);
    #1;
    check("halted_set", {127'd0, bus.halted}, 128'd1);
    check("retire_incl_break", {64'd0, bus.retire_cnt}, 128'(n_sent));
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("halted_in_ready", {127'd0, bus.in_ready}, 128'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("halted_sticky", {127'd0, bus.halted}, 128'd1);
    check("retire_frozen", {64'd0, bus.retire_cnt}, 128'(n_sent));
    check("queue_drained", 128'(q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24100006_wbu_pipe.md
Name: ysyx_24100006_wbu_pipe

Overview:
Parametrised, registered write-back stage. It accepts one retiring instruction per cycle from MEM_WB over valid/ready. It selects the GPR and CSR write data, suppresses writes to x0, and presents registered write ports to the register files. It also keeps a retire counter and a sticky halt on ebreak; the halt replaces the DPI trap call with a port.

Parameters:
XLEN, 32, data/PC width
GPR_AW, 4, GPR address width (4 = RV32E, 5 = RV32I)
CSR_AW, 12, CSR address width
IRQ_NW, 8, interrupt number width
CNT_W, 64, retire counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0)
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept
in_pc  in  XLEN  instruction PC
in_imm  in  XLEN  sign-extended immediate
in_alu  in  XLEN  ALU result
in_mem  in  XLEN  extended load data
in_csr_rdata  in  XLEN  CSR read data
in_rs1  in  XLEN  rs1 value
in_gpr_we  in  1  GPR write request
in_gpr_addr  in  GPR_AW  rd
in_gpr_sel  in  3  0 imm, 1 alu, 2 pc+4, 3 mem, 4 csr_rdata, 5-7 reserved
in_csr_we  in  1  CSR write request
in_csr_addr  in  CSR_AW  CSR address
in_csr_sel  in  2  0 pc, 1 rs1, 2 csr_rdata|rs1, 3 csr_rdata&~rs1
in_irq  in  1  trap/interrupt taken
in_irq_no  in  IRQ_NW  cause number
in_break  in  1  ebreak retiring
out_valid  out  1  registered entry valid
out_ready  in  1  register files accept
gpr_we  out  1  GPR write strobe
gpr_waddr  out  GPR_AW  GPR address
gpr_wdata  out  XLEN  GPR data
csr_we  out  1  CSR write strobe
csr_waddr  out  CSR_AW  CSR address
csr_wdata  out  XLEN  CSR data
irq_o  out  1  registered in_irq
irq_no_o  out  IRQ_NW  registered cause
halted  out  1  sticky ebreak halt
retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset (reset==0 at posedge clk): out_valid, gpr_we, csr_we, irq_o, halted = 0; all address, data, irq_no_o and retire_cnt = 0. Reset has priority over everything. A held entry is dropped.
- in_ready = !halted && (!out_valid || out_ready). Pure combinational; this gives a full-throughput single skid stage.
- Accept = in_valid && in_ready. On accept, all outputs load next cycle (latency 1) and out_valid=1.
- gpr_we <= in_gpr_we && (in_gpr_addr != 0). gpr_wdata comes from the sel mux; pc+4 wraps mod 2^XLEN. Reserved sel values give wdata = 0 and gpr_we = 0.
- csr_we <= in_csr_we. csr_wdata comes from the csr_sel mux.
- Output handshake = out_valid && out_ready. Write strobes are meaningful only while out_valid. Consumers commit on the handshake only.
- After a handshake with no new accept: out_valid, gpr_we, csr_we, irq_o <= 0. Data fields hold their last value.
- out_valid && !out_ready: all outputs hold stable and in_ready = 0.
- Simultaneous handshake and accept: the new entry replaces the old one with no bubble.
- retire_cnt increments by 1 on each output handshake and wraps at 2^CNT_W.
- halted is set on the output handshake of an entry whose registered break bit is 1. After that, in_ready = 0 until reset. The break entry itself is counted and its writes commit.
- in_break and in_irq both 1: irq_o is still passed through, and halt still sets.

Optional Feature:
WBU_DIFFTEST_EN.
- Defined: adds inputs in_npc (XLEN) and mtvec (XLEN) and output npc_dbg (XLEN, reset 0). On each output handshake, npc_dbg <= registered irq ? mtvec : registered npc, sampled at accept. npc_dbg is updated one cycle after commit, for difftest.
- Undefined: these ports and registers do not exist, and the behaviour is otherwise identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles with in_valid=1 -> out_valid=0, retire_cnt=0, in_ready=1 after release.
- Stream of 4 ALU writes, rd=1..4, alu=0x10..0x13, out_ready=1 -> one per cycle, gpr_wdata matches 1 cycle later, retire_cnt=4.
- x0 write with sel=2, pc=0xFFFFFFFC, rd=0 -> gpr_we=0, gpr_wdata=0x00000000 (wrap).
- Backpressure: out_ready=0 for 3 cycles mid-stream -> in_ready=0, outputs stable, no entry lost or duplicated.
- CSR set: csr_sel=2, csr_rdata=0x0F, rs1=0xF0 -> csr_wdata=0xFF, csr_we=1.
- ebreak: commit a break entry -> halted=1 the next cycle, in_ready=0 thereafter, retire_cnt includes the break entry.
